// File: rtl/iram_loadable.sv
// Loadable instruction RAM: 1-cycle registered reads in IDLE, streamed program load via a small FSM.
// Optional load checksum output ld_sum is enabled by defining IRAM_LOADABLE_CHECKSUM_EN.
module iram_loadable #(
   parameter int unsigned         DATA_W   = 8,
   parameter int unsigned         ADDR_W   = 8,
   parameter int unsigned         DEPTH    = 256,
   parameter logic [DATA_W-1:0]   OOR_WORD = DATA_W'(2)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] addr,
   input  logic              rd_en,
   output logic [DATA_W-1:0] dout,
   output logic              dout_valid,
   input  logic              ld_start,
   input  logic [ADDR_W-1:0] ld_base,
   input  logic [ADDR_W:0]   ld_count,
   input  logic              ld_valid,
   input  logic [DATA_W-1:0] ld_data,
   output logic              ld_ready,
   output logic              ld_done,
   output logic              busy
`ifdef IRAM_LOADABLE_CHECKSUM_EN
   ,output logic [DATA_W-1:0] ld_sum
`endif
);

   localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = ADDR_W + 1;

   typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

   state_t             state, state_nxt;
   logic [DATA_W-1:0]  mem [DEPTH];
   logic [ADDR_W-1:0]  ptr;
   logic [CNT_W-1:0]   remaining;
   logic               start_ok;
   logic               wr_en;
   logic               in_range;

   // Next-state and load handshake decode
   always_comb begin
      state_nxt = state;
      start_ok  = 1'b0;
      wr_en     = 1'b0;
      case (state)
         IDLE: begin
            if (ld_start) begin
               start_ok  = 1'b1;
               state_nxt = (ld_count == '0) ? DONE : LOAD;
            end
         end
         LOAD: begin
            if (ld_valid) begin
               wr_en = 1'b1;
               if (remaining == CNT_W'(1)) state_nxt = DONE;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Status flags registered from the next state so they track the state register exactly
   always_ff @(posedge clk) begin
      if (rst) begin
         busy     <= 1'b0;
         ld_ready <= 1'b0;
         ld_done  <= 1'b0;
      end else begin
         busy     <= (state_nxt != IDLE);
         ld_ready <= (state_nxt == LOAD);
         ld_done  <= (state_nxt == DONE);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr       <= '0;
         remaining <= '0;
      end else if (start_ok) begin
         ptr       <= ADDR_W'(ld_base % DEPTH);
         remaining <= ld_count;
      end else if (wr_en) begin
         ptr       <= (ptr == ADDR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
         remaining <= remaining - 1'b1;
      end
   end

   // Array has no reset so an aborted load leaves its written words in place
   always_ff @(posedge clk) begin
      if (wr_en && !rst) mem[IDX_W'(ptr)] <= ld_data;
   end

   assign in_range = ({1'b0, addr} < CNT_W'(DEPTH));

   always_ff @(posedge clk) begin
      if (rst) begin
         dout       <= '0;
         dout_valid <= 1'b0;
      end else begin
         dout_valid <= 1'b0;
         if (state == IDLE && rd_en) begin
            dout_valid <= 1'b1;
            dout       <= in_range ? mem[IDX_W'(addr)] : OOR_WORD;
         end
      end
   end

`ifdef IRAM_LOADABLE_CHECKSUM_EN
   always_ff @(posedge clk) begin
      if (rst)           ld_sum <= '0;
      else if (start_ok) ld_sum <= '0;
      else if (wr_en)    ld_sum <= ld_sum + ld_data;
   end
`endif

endmodule

// File: tb/tb_iram_loadable.sv
// Scoreboard bench for iram_loadable (DEPTH = 121); read expectations are queued when rd_en is driven.
module tb_iram_loadable;
   localparam int unsigned DATA_W = 8;
   localparam int unsigned ADDR_W = 8;
   localparam int unsigned DEPTH  = 121;

   logic              clk = 1'b0;
   logic              rst;
   logic [ADDR_W-1:0] addr;
   logic              rd_en;
   logic [DATA_W-1:0] dout;
   logic              dout_valid;
   logic              ld_start;
   logic [ADDR_W-1:0] ld_base;
   logic [ADDR_W:0]   ld_count;
   logic              ld_valid;
   logic [DATA_W-1:0] ld_data;
   logic              ld_ready;
   logic              ld_done;
   logic              busy;
`ifdef IRAM_LOADABLE_CHECKSUM_EN
   logic [DATA_W-1:0] ld_sum;
`endif

   int checks   = 0;
   int failures = 0;

   logic [7:0] model [DEPTH];
   logic [7:0] exp_q [$];
   logic [7:0] model_sum;
   logic [7:0] wbuf  [16];
   bit         vpat  [16];

   iram_loadable #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .OOR_WORD(8'd2)) dut (
      .clk(clk), .rst(rst), .addr(addr), .rd_en(rd_en), .dout(dout), .dout_valid(dout_valid),
      .ld_start(ld_start), .ld_base(ld_base), .ld_count(ld_count), .ld_valid(ld_valid),
      .ld_data(ld_data), .ld_ready(ld_ready), .ld_done(ld_done), .busy(busy)
`ifdef IRAM_LOADABLE_CHECKSUM_EN
      , .ld_sum(ld_sum)
`endif
   );

   always #5 clk = ~clk;

   // Read-data scoreboard: every dout_valid must match the oldest queued expectation
   always @(negedge clk) begin
      logic [7:0] e;
      if (rst === 1'b0 && dout_valid === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL rd_unexpected dout_valid=1 with nothing pending, dout=%h", dout);
         end else begin
            e = exp_q.pop_front();
            if (dout !== e) begin
               failures++;
               $display("FAIL rd_data dout=%h expected=%h", dout, e);
            end
         end
      end
   end

   task automatic do_read(input logic [7:0] a);
      @(negedge clk);
      rd_en = 1'b1;
      addr  = a;
      exp_q.push_back((32'(a) < DEPTH) ? model[a] : 8'h02);
      @(negedge clk);
      rd_en = 1'b0;
   endtask

   task automatic set_all_valid();
      for (int i = 0; i < 16; i++) vpat[i] = 1'b1;
   endtask

   task automatic do_load(input logic [7:0] base, input logic [8:0] count, input int ncyc,
                          input bit rd_during, input logic [7:0] rd_addr);
      logic [7:0] p;
      logic [7:0] dout_hold;
      int         acc;
      @(negedge clk);
      ld_start = 1'b1;
      ld_base  = base;
      ld_count = count;
      p         = 8'(32'(base) % DEPTH);
      acc       = 0;
      model_sum = 8'h00;
      @(negedge clk);
      ld_start  = 1'b0;
      dout_hold = dout;
      for (int k = 0; k < ncyc && acc < int'(count); k++) begin
         checks++;
         if (ld_ready !== 1'b1 || busy !== 1'b1 || ld_done !== 1'b0) begin
            failures++;
            $display("FAIL load_status cyc=%0d ready=%b busy=%b done=%b expected 1 1 0", k, ld_ready, busy, ld_done);
         end
`ifdef IRAM_LOADABLE_CHECKSUM_EN
         if (k == 0) begin
            checks++;
            if (ld_sum !== 8'h00) begin
               failures++;
               $display("FAIL sum_clear ld_sum=%h expected=00", ld_sum);
            end
         end
`endif
         ld_valid = vpat[k];
         ld_data  = vpat[k] ? wbuf[acc] : 8'hEE;
         rd_en    = rd_during && !vpat[k];
         addr     = rd_addr;
         if (vpat[k]) begin
            model[p]  = wbuf[acc];
            model_sum = model_sum + wbuf[acc];
            p         = (32'(p) == DEPTH - 1) ? 8'd0 : p + 8'd1;
            acc++;
         end
         @(negedge clk);
      end
      ld_valid = 1'b0;
      rd_en    = 1'b0;
      checks++;
      if (ld_done !== 1'b1 || ld_ready !== 1'b0 || busy !== 1'b1) begin
         failures++;
         $display("FAIL load_done done=%b ready=%b busy=%b expected 1 0 1", ld_done, ld_ready, busy);
      end
`ifdef IRAM_LOADABLE_CHECKSUM_EN
      checks++;
      if (ld_sum !== model_sum) begin
         failures++;
         $display("FAIL sum_done ld_sum=%h expected=%h", ld_sum, model_sum);
      end
`endif
      if (rd_during) begin
         checks++;
         if (dout !== dout_hold) begin
            failures++;
            $display("FAIL dout_hold dout=%h expected=%h", dout, dout_hold);
         end
      end
      @(negedge clk);
      checks++;
      if (ld_done !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL load_idle done=%b busy=%b expected 0 0", ld_done, busy);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; ld_start = 1'b1; ld_count = 9'd3; rd_en = 1'b1; ld_valid = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (dout !== 8'h00 || dout_valid !== 1'b0) begin
         failures++;
         $display("FAIL reset_read dout=%h valid=%b expected 00 0", dout, dout_valid);
      end
      checks++;
      if (busy !== 1'b0 || ld_ready !== 1'b0 || ld_done !== 1'b0) begin
         failures++;
         $display("FAIL reset_status busy=%b ready=%b done=%b expected 0 0 0", busy, ld_ready, ld_done);
      end
`ifdef IRAM_LOADABLE_CHECKSUM_EN
      checks++;
      if (ld_sum !== 8'h00) begin
         failures++;
         $display("FAIL reset_sum ld_sum=%h expected=00", ld_sum);
      end
`endif
      rst = 1'b0; ld_start = 1'b0; rd_en = 1'b0; ld_valid = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_basic();
      set_all_valid();
      wbuf[0] = 8'h07; wbuf[1] = 8'h08; wbuf[2] = 8'h03;
      do_load(8'd0, 9'd3, 3, 1'b0, 8'd0);
      for (int i = 0; i < 3; i++) do_read(8'(i));
   endtask

   task automatic test_wrap();
      set_all_valid();
      wbuf[0] = 8'hAA; wbuf[1] = 8'hBB;
      do_load(8'd120, 9'd2, 2, 1'b0, 8'd0);
      do_read(8'd120); do_read(8'd0); do_read(8'd121); do_read(8'd200);
      wbuf[0] = 8'h44;
      do_load(8'd125, 9'd1, 1, 1'b0, 8'd0);
      do_read(8'd4);
   endtask

   task automatic test_gaps();
      set_all_valid();
      for (int i = 0; i < 5; i++) wbuf[i] = 8'h60 + 8'(i);
      do_load(8'd8, 9'd5, 5, 1'b0, 8'd0);
      vpat[0] = 1; vpat[1] = 0; vpat[2] = 1; vpat[3] = 0; vpat[4] = 1; vpat[5] = 1;
      for (int i = 0; i < 4; i++) wbuf[i] = 8'h51 + 8'(i);
      do_load(8'd8, 9'd4, 6, 1'b1, 8'd1);
      for (int i = 8; i < 13; i++) do_read(8'(i));
   endtask

   task automatic test_reset_abort();
      set_all_valid();
      for (int i = 0; i < 5; i++) wbuf[i] = 8'h70 + 8'(i);
      do_load(8'd20, 9'd5, 5, 1'b0, 8'd0);
      @(negedge clk);
      ld_start = 1'b1; ld_base = 8'd20; ld_count = 9'd5;
      @(negedge clk);
      ld_start = 1'b0; ld_valid = 1'b1; ld_data = 8'h80; model[20] = 8'h80;
      @(negedge clk);
      ld_data = 8'h81; model[21] = 8'h81;
      @(negedge clk);
      rst = 1'b1; ld_data = 8'h99;
      @(negedge clk);
      rst = 1'b0; ld_valid = 1'b0;
      checks++;
      if (busy !== 1'b0 || ld_ready !== 1'b0 || ld_done !== 1'b0) begin
         failures++;
         $display("FAIL abort_status busy=%b ready=%b done=%b expected 0 0 0", busy, ld_ready, ld_done);
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (ld_done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL abort_no_done cyc=%0d done=%b busy=%b expected 0 0", i, ld_done, busy);
         end
      end
      for (int i = 20; i < 25; i++) do_read(8'(i));
   endtask

   task automatic test_same_edge();
      set_all_valid();
      wbuf[0] = 8'h13; wbuf[1] = 8'h21;
      do_load(8'd5, 9'd2, 2, 1'b0, 8'd0);
      @(negedge clk);
      rd_en = 1'b1; addr = 8'd5; exp_q.push_back(8'h13);
      ld_start = 1'b1; ld_base = 8'd5; ld_count = 9'd1;
      @(negedge clk);
      rd_en = 1'b0; ld_start = 1'b0; ld_valid = 1'b1; ld_data = 8'h19; model[5] = 8'h19;
      @(negedge clk);
      ld_valid = 1'b0;
      checks++;
      if (ld_done !== 1'b1) begin
         failures++;
         $display("FAIL same_edge_done ld_done=%b expected=1", ld_done);
      end
      do_read(8'd5);
      @(negedge clk);
      ld_start = 1'b1; ld_base = 8'd6; ld_count = 9'd0;
      @(negedge clk);
      ld_valid = 1'b1; ld_data = 8'hEE; ld_count = 9'd3;
      checks++;
      if (ld_done !== 1'b1 || busy !== 1'b1 || ld_ready !== 1'b0) begin
         failures++;
         $display("FAIL zero_done done=%b busy=%b ready=%b expected 1 1 0", ld_done, busy, ld_ready);
      end
`ifdef IRAM_LOADABLE_CHECKSUM_EN
      checks++;
      if (ld_sum !== 8'h00) begin
         failures++;
         $display("FAIL zero_sum ld_sum=%h expected=00", ld_sum);
      end
`endif
      @(negedge clk);
      ld_start = 1'b0; ld_valid = 1'b0;
      checks++;
      if (ld_done !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL zero_idle done=%b busy=%b expected 0 0", ld_done, busy);
      end
      do_read(8'd6);
   endtask

`ifdef IRAM_LOADABLE_CHECKSUM_EN
   task automatic test_checksum();
      set_all_valid();
      wbuf[0] = 8'hFF; wbuf[1] = 8'h02; wbuf[2] = 8'h10;
      do_load(8'd30, 9'd3, 3, 1'b0, 8'd0);
      @(negedge clk);
      checks++;
      if (ld_sum !== 8'h11) begin
         failures++;
         $display("FAIL sum_stable ld_sum=%h expected=11", ld_sum);
      end
      wbuf[0] = 8'h05;
      do_load(8'd33, 9'd1, 1, 1'b0, 8'd0);
   endtask
`endif

   initial begin
      rst = 1'b1; addr = '0; rd_en = 1'b0; ld_start = 1'b0; ld_base = '0;
      ld_count = '0; ld_valid = 1'b0; ld_data = '0;
      test_reset();
      test_basic();
      test_wrap();
      test_gaps();
      test_reset_abort();
      test_same_edge();
`ifdef IRAM_LOADABLE_CHECKSUM_EN
      test_checksum();
`endif
      repeat (2) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL rd_missing pending=%0d expected=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
